// File: rtl/pixel_dma_pkg.sv
// Shared definitions for pixel_dma_writer: FSM state encoding, full-word strobe and lane-mask helper.
package pixel_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WRITE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] WSTRB_FULL = 4'b1111;

  // Byte-enable mask for n filled lanes (n = 0..4), lane 0 first.
  function automatic logic [3:0] lane_mask(input logic [2:0] n);
    logic [3:0] m;
    m = 4'b0000;
    case (n)
      3'd1: m = 4'b0001;
      3'd2: m = 4'b0011;
      3'd3: m = 4'b0111;
      3'd4: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pixel_dma_writer_packer.sv
// pixel_packer: little-endian byte-lane accumulator; clear zeroes the word so unfilled lanes read 0.
module pixel_packer
  import pixel_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [1:0]  cnt,
  output logic [3:0]  mask
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= 32'h0;
      cnt  <= 2'd0;
    end else if (push) begin
      word[{cnt, 3'b000} +: 8] <= data;
      cnt                      <= cnt + 2'd1;
    end
  end

  assign mask = lane_mask({1'b0, cnt});

endmodule

// File: rtl/pixel_dma_writer.sv
// pixel_dma_writer: packs an 8-bit pixel stream into 32-bit words and writes them over the picorv32
// native memory bus. Optional early-end with partial word is enabled by DMA_PARTIAL_FLUSH_EN.
//
// Handshakes: a pixel moves on a rising edge where pix_valid && pix_ready; a bus write completes on
// a rising edge where mem_valid && mem_ready. mem_addr/mem_wdata/mem_wstrb hold while mem_valid waits.
module pixel_dma_writer
  import pixel_dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              flush,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              pix_ready,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_written,
  output state_t            state_dbg
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic             last_q;
  logic             pix_fire;
  logic             pack_clear;
  logic [1:0]       pack_cnt;
  logic [3:0]       pack_mask;
  logic [LEN_W-1:0] ww_next;

  assign pix_fire   = pix_valid && pix_ready && (state == S_FILL);
  assign pack_clear = ((state == S_IDLE) && start && !busy) ||
                      ((state == S_WRITE) && mem_ready);
  assign ww_next    = words_written + LEN_W'(1);
  assign state_dbg  = state;

`ifdef DMA_PARTIAL_FLUSH_EN
  logic [2:0] fill_n;
  assign fill_n = {1'b0, pack_cnt} + {2'b00, pix_fire};
`else
  logic unused_cfg;
  assign unused_cfg = &{1'b0, flush, pack_mask};
`endif

  pixel_packer u_packer (
    .clk   (clk),
    .reset (reset),
    .clear (pack_clear),
    .push  (pix_fire),
    .data  (pix_data),
    .word  (mem_wdata),
    .cnt   (pack_cnt),
    .mask  (pack_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      len_q         <= '0;
      last_q        <= 1'b0;
      pix_ready     <= 1'b0;
      mem_valid     <= 1'b0;
      mem_addr      <= '0;
      mem_wstrb     <= 4'b0000;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // busy is still high for the one cycle done is shown, so a start there is ignored
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !busy) begin
            busy          <= 1'b1;
            mem_addr      <= {base_addr[ADDR_W-1:2], 2'b00};
            len_q         <= len_words;
            last_q        <= 1'b0;
            words_written <= '0;
            if (len_words == '0) begin
              state <= S_DONE;
            end else begin
              state     <= S_FILL;
              pix_ready <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (pix_fire && (pack_cnt == 2'd3)) begin
            state     <= S_WRITE;
            pix_ready <= 1'b0;
            mem_valid <= 1'b1;
            mem_wstrb <= WSTRB_FULL;
`ifdef DMA_PARTIAL_FLUSH_EN
            last_q    <= flush;
`endif
          end
`ifdef DMA_PARTIAL_FLUSH_EN
          else if (flush) begin
            pix_ready <= 1'b0;
            last_q    <= 1'b1;
            if (fill_n != 3'd0) begin
              state     <= S_WRITE;
              mem_valid <= 1'b1;
              mem_wstrb <= pix_fire ? lane_mask(fill_n) : pack_mask;
            end else begin
              state <= S_DONE;
            end
          end
`endif
        end
        S_WRITE: begin
          if (mem_ready) begin
            mem_valid     <= 1'b0;
            mem_addr      <= mem_addr + ADDR_W'(4);
            words_written <= ww_next;
            if (last_q || (ww_next == len_q)) begin
              state <= S_DONE;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          pix_ready <= 1'b1;
          state     <= S_FILL;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_dma_writer.sv
// Bench for pixel_dma_writer: table of full transfers against a RAM responder plus directed corner sequences.
module tb_pixel_dma_writer;
  import pixel_dma_pkg::*;

  localparam int EW      = 68;
  localparam int TIMEOUT = 400;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len_words;
  logic        flush;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        busy;
  logic        done;
  logic [15:0] words_written;
  state_t      state_dbg;

  logic [EW-1:0] exp_q[$];
  int n_checks;
  int n_pass;

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    logic [7:0]  pix0;
    int          delay;
    int          restart_at;
    logic        spur;
    logic [15:0] exp_ww;
    int          exp_first_mv;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_last_data;
  } vec_t;

  vec_t vecs[5];

  pixel_dma_writer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .len_words     (len_words),
    .flush         (flush),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_ready     (pix_ready),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard model: word i lands at aligned base + 4i and carries pixels pix0+4i .. pix0+4i+3
  task automatic load_expected(input vec_t v);
    logic [31:0] a;
    logic [7:0]  p;
    exp_q.delete();
    for (int i = 0; i < int'(v.len); i++) begin
      a = (v.base & 32'hFFFF_FFFC) + 32'(4 * i);
      p = v.pix0 + 8'(4 * i);
      exp_q.push_back({a, p + 8'd3, p + 8'd2, p + 8'd1, p, 4'b1111});
    end
  endtask

  // driver + responder for one transfer with a continuous pixel stream
  task automatic run_xfer(input vec_t v, output int n_wr, output int n_done, output int first_mv,
                          output logic [31:0] last_addr, output logic [31:0] last_data);
    logic [7:0]    pix;
    logic          acc;
    logic          finished;
    int            wcnt;
    logic [31:0]   h_addr;
    logic [31:0]   h_data;
    logic [3:0]    h_strb;
    logic [EW-1:0] e;
    n_wr = 0; n_done = 0; first_mv = -1; wcnt = 0; finished = 1'b0;
    last_addr = 32'h0; last_data = 32'h0;
    h_addr = 32'h0; h_data = 32'h0; h_strb = 4'h0;
    pix = v.pix0;
    load_expected(v);
    base_addr = v.base; len_words = v.len; start = 1'b1;
    step();
    start = 1'b0;
    pix_valid = 1'b1;
    pix_data  = pix;
    for (int cyc = 0; cyc < TIMEOUT; cyc++) begin
      if (n_done > 0 && !busy) begin
        finished = 1'b1;
        break;
      end
      if (cyc == v.restart_at) begin
        start = 1'b1; base_addr = 32'hDEAD_0000; len_words = 16'd7;
      end else begin
        start = 1'b0;
      end
      acc = pix_ready;
      mem_ready = v.spur;
      if (done) n_done++;
      if (mem_valid) begin
        if (first_mv < 0) first_mv = cyc;
        check("pix_ready_low_in_write", {31'b0, pix_ready}, 32'd0);
        if (wcnt > 0) begin
          check("hold_addr", mem_addr, h_addr);
          check("hold_wdata", mem_wdata, h_data);
          check("hold_wstrb", {28'b0, mem_wstrb}, {28'b0, h_strb});
        end
        h_addr = mem_addr; h_data = mem_wdata; h_strb = mem_wstrb;
        if (wcnt == v.delay) begin
          mem_ready = 1'b1;
          wcnt = 0;
          n_wr++;
          last_addr = mem_addr;
          last_data = mem_wdata;
          if (exp_q.size() == 0) begin
            check("extra_write", 32'(n_wr), 32'(v.len));
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", mem_addr, e[67:36]);
            check("wr_data", mem_wdata, e[35:4]);
            check("wr_strb", {28'b0, mem_wstrb}, {28'b0, e[3:0]});
          end
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end
      step();
      if (acc) begin
        pix = pix + 8'd1;
        pix_data = pix;
      end
    end
    start = 1'b0; mem_ready = 1'b0; pix_valid = 1'b0;
    check("xfer_finished", {31'b0, finished}, 32'd1);
  endtask

  initial begin
    int          n_wr;
    int          n_done;
    int          first_mv;
    int          mv_seen;
    logic        found;
    logic [31:0] la;
    logic [31:0] ld;
    n_checks = 0; n_pass = 0;
    reset = 1'b1; start = 1'b0; base_addr = 32'h0; len_words = 16'h0; flush = 1'b0;
    pix_valid = 1'b0; pix_data = 8'h0; mem_ready = 1'b0;

    vecs[0] = '{32'h0000_0200, 16'd2, 8'h01, 0, -1, 1'b0, 16'd2, 4,  32'h0000_0204, 32'h0807_0605};
    vecs[1] = '{32'h0000_1000, 16'd1, 8'h10, 5,  3, 1'b1, 16'd1, 4,  32'h0000_1000, 32'h1312_1110};
    vecs[2] = '{32'h0000_0300, 16'd0, 8'h00, 0,  0, 1'b1, 16'd0, -1, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFC, 16'd2, 8'hA0, 0, -1, 1'b0, 16'd2, 4,  32'h0000_0000, 32'hA7A6_A5A4};
    vecs[4] = '{32'h0000_0403, 16'd3, 8'hFE, 1,  8, 1'b1, 16'd3, 4,  32'h0000_0408, 32'h0908_0706};

    repeat (3) step();
    check("rst_pix_ready", {31'b0, pix_ready}, 32'd0);
    check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_words_written", {16'b0, words_written}, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i], n_wr, n_done, first_mv, la, ld);
      check($sformatf("v%0d_done_pulses", i), 32'(n_done), 32'd1);
      check($sformatf("v%0d_n_writes", i), 32'(n_wr), 32'(vecs[i].len));
      check($sformatf("v%0d_words_written", i), {16'b0, words_written}, {16'b0, vecs[i].exp_ww});
      check($sformatf("v%0d_first_mem_valid", i), 32'(first_mv), 32'(vecs[i].exp_first_mv));
      check($sformatf("v%0d_exp_q_empty", i), 32'(exp_q.size()), 32'd0);
      if (vecs[i].len != 16'd0) begin
        check($sformatf("v%0d_last_addr", i), la, vecs[i].exp_last_addr);
        check($sformatf("v%0d_last_data", i), ld, vecs[i].exp_last_data);
      end
      step();
    end

    // len=0: done appears two cycles after the start cycle, never a bus request
    base_addr = 32'h0000_0300; len_words = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("len0_done_c1", {31'b0, done}, 32'd0);
    check("len0_busy_c1", {31'b0, busy}, 32'd1);
    check("len0_mv_c1", {31'b0, mem_valid}, 32'd0);
    step();
    check("len0_done_c2", {31'b0, done}, 32'd1);
    check("len0_mv_c2", {31'b0, mem_valid}, 32'd0);
    step();
    check("len0_done_c3", {31'b0, done}, 32'd0);
    check("len0_busy_c3", {31'b0, busy}, 32'd0);

    // two pixels then flush
    base_addr = 32'h0000_0800; len_words = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    pix_valid = 1'b1; pix_data = 8'hAA;
    step();
    pix_data = 8'hBB;
    step();
    pix_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef DMA_PARTIAL_FLUSH_EN
    check("flush_mem_valid", {31'b0, mem_valid}, 32'd1);
    check("flush_addr", mem_addr, 32'h0000_0800);
    check("flush_wdata", mem_wdata, 32'h0000_BBAA);
    check("flush_wstrb", {28'b0, mem_wstrb}, 32'h3);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      if (done) found = 1'b1;
      else step();
    end
    check("flush_done_seen", {31'b0, found}, 32'd1);
    check("flush_words_written", {16'b0, words_written}, 32'd1);
    step();
    check("flush_busy_clear", {31'b0, busy}, 32'd0);
    // flush with no lanes filled ends without a write
    base_addr = 32'h0000_0900; len_words = 16'd3; start = 1'b1;
    step();
    start = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    found = 1'b0; mv_seen = 0;
    for (int c = 0; c < 6 && !found; c++) begin
      if (mem_valid) mv_seen++;
      if (done) found = 1'b1;
      else step();
    end
    check("flush0_done_seen", {31'b0, found}, 32'd1);
    check("flush0_no_write", 32'(mv_seen), 32'd0);
    check("flush0_words_written", {16'b0, words_written}, 32'd0);
    step();
`else
    mv_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_valid) mv_seen++;
      step();
    end
    check("noflush_no_write", 32'(mv_seen), 32'd0);
    check("noflush_still_busy", {31'b0, busy}, 32'd1);
    check("noflush_no_words", {16'b0, words_written}, 32'd0);
`endif

    // reset while a write is pending
    reset = 1'b1;
    step();
    reset = 1'b0;
    base_addr = 32'h0000_0500; len_words = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    pix_valid = 1'b1; pix_data = 8'h55;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_valid) found = 1'b1;
      else step();
    end
    pix_valid = 1'b0;
    check("rstmid_write_reached", {31'b0, found}, 32'd1);
    reset = 1'b1;
    step();
    check("rstmid_mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rstmid_busy", {31'b0, busy}, 32'd0);
    check("rstmid_pix_ready", {31'b0, pix_ready}, 32'd0);
    check("rstmid_words_written", {16'b0, words_written}, 32'd0);
    reset = 1'b0;
    step();

    // normal operation after reset
    run_xfer(vecs[0], n_wr, n_done, first_mv, la, ld);
    check("post_rst_done_pulses", 32'(n_done), 32'd1);
    check("post_rst_words_written", {16'b0, words_written}, 32'd2);
    check("post_rst_last_data", ld, 32'h0807_0605);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
